// File: rtl/ysyx_22050019_ifu_if.sv
// Fetch-side bus of the IFU: icache read channel, decode handoff and redirect input.
// The master modport is the IFU; the slave modport is the icache/decode/branch side.
interface ysyx_22050019_ifu_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  ar_valid_o;
    logic                  ar_ready_i;
    logic [ADDR_WIDTH-1:0] ar_addr_o;
    logic                  r_valid_i;
    logic                  r_ready_o;
    logic [1:0]            r_resp_i;
    logic [DATA_WIDTH-1:0] r_data_i;
    logic                  inst_valid_o;
    logic                  inst_ready_i;
    logic [31:0]           inst_o;
    logic [ADDR_WIDTH-1:0] pc_o;
    logic                  inst_err_o;
    logic                  redirect_valid_i;
    logic [ADDR_WIDTH-1:0] redirect_pc_i;

    modport master (
        output ar_valid_o, ar_addr_o, r_ready_o,
        output inst_valid_o, inst_o, pc_o, inst_err_o,
        input  ar_ready_i, r_valid_i, r_resp_i, r_data_i,
        input  inst_ready_i, redirect_valid_i, redirect_pc_i
    );

    modport slave (
        input  ar_valid_o, ar_addr_o, r_ready_o,
        input  inst_valid_o, inst_o, pc_o, inst_err_o,
        output ar_ready_i, r_valid_i, r_resp_i, r_data_i,
        output inst_ready_i, redirect_valid_i, redirect_pc_i
    );
endinterface

// File: rtl/ysyx_22050019_ifu.sv
// Instruction fetch unit: one outstanding icache read, 32-bit word select, decode handoff,
// and PC redirect with drop of the in-flight response.
module ysyx_22050019_ifu #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h0000_0000_8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_22050019_ifu_if.master        bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] pc, pc_nx;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  kill, kill_nx;
    logic                  load_inst;
    logic [31:0]           inst_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] redirect_target;

    assign redirect_target = bus.redirect_pc_i & ~ADDR_WIDTH'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        kill_nx   = kill;
        load_inst = 1'b0;
        case (state)
            S_IDLE: state_nx = S_REQ;
            S_REQ: begin
                if (bus.redirect_valid_i) kill_nx = 1'b1;
                if (bus.ar_ready_i)       state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (bus.r_valid_i) begin
                    // a redirect landing on the response cycle drops it just like a pending kill
                    if (kill || bus.redirect_valid_i) begin
                        kill_nx  = 1'b0;
                        state_nx = S_REQ;
                    end else begin
                        load_inst = 1'b1;
                        state_nx  = S_OUT;
                    end
                end else if (bus.redirect_valid_i) begin
                    kill_nx = 1'b1;
                end
            end
            S_OUT: begin
                if (bus.inst_ready_i) begin
                    pc_nx    = pc + ADDR_WIDTH'(4);
                    state_nx = S_REQ;
                end
                if (bus.redirect_valid_i) state_nx = S_REQ;
            end
            default: state_nx = S_IDLE;
        endcase
        if (bus.redirect_valid_i) pc_nx = redirect_target;
    end

    // request address is captured on entry to S_REQ so a redirect cannot disturb a pending request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            kill     <= 1'b0;
            req_addr <= RESET_PC & ~ADDR_WIDTH'(7);
            inst_q   <= '0;
            pc_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            pc   <= pc_nx;
            kill <= kill_nx;
            if (state_nx == S_REQ && state != S_REQ) req_addr <= pc_nx & ~ADDR_WIDTH'(7);
            if (load_inst) begin
                inst_q <= pc[2] ? bus.r_data_i[63:32] : bus.r_data_i[31:0];
                pc_q   <= pc;
                err_q  <= (bus.r_resp_i != 2'b00);
            end
        end
    end

    assign bus.ar_valid_o   = (state == S_REQ);
    assign bus.r_ready_o    = (state == S_WAIT);
    assign bus.inst_valid_o = (state == S_OUT);
    assign bus.ar_addr_o    = req_addr;
    assign bus.inst_o       = inst_q;
    assign bus.pc_o         = pc_q;
    assign bus.inst_err_o   = err_q;
endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// Bench for ysyx_22050019_ifu: icache responder plus an instruction-stream model
// (expected PC sequence with redirects), directed scenarios then randomized traffic.
module tb_ysyx_22050019_ifu;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22050019_ifu_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus();

    ysyx_22050019_ifu #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // memory image: fixed words at the reset vector, hashed contents elsewhere
    function automatic logic [31:0] word(input logic [63:0] a);
        logic [31:0] h;
        if (a == 64'h8000_0000) return 32'h0010_0093;
        if (a == 64'h8000_0004) return 32'h0000_0013;
        h = a[31:0] * 32'h9E37_79B1;
        return h ^ a[63:32] ^ {h[15:0], h[31:16]} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] mem(input logic [63:0] d);
        return {word(d + 64'd4), word(d)};
    endfunction

    function automatic logic [1:0] resp_of(input logic [63:0] d);
        logic [31:0] h;
        if (d == 64'h8000_0200) return 2'b10;
        if (d[63:16] == 48'h0000_0000_8000) return 2'b00;
        h = word(d);
        return (h[4:2] == 3'b000) ? {1'b1, h[0]} : 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    // stimulus knobs
    bit          rnd = 1'b0;
    bit          d_inst_ready = 1'b1;
    int          d_lat = 0;
    bit          d_redir = 1'b0;
    logic [63:0] d_redir_pc = '0;
    int          redir_hold = 0;

    // icache responder
    bit          pend = 1'b0;
    logic [63:0] pend_addr = '0;
    int          lat_cnt = 0;

    // reference: PC of the next instruction decode should receive
    logic [63:0] exp_pc = RESET_PC;

    logic [63:0] ar_log[$];
    logic [63:0] ip_log[$];
    logic [31:0] iw_log[$];
    bit          ie_log[$];
    int          ar_cyc[$];
    int          inst_cyc[$];
    int          cyc = 0;
    int          since_inst = 0;

    bit          pv_ar_wait = 1'b0;
    logic [63:0] pv_ar_addr = '0;
    bit          pv_inst_hold = 1'b0;
    logic [31:0] pv_inst = '0;
    logic [63:0] pv_pc = '0;
    logic        pv_err = 1'b0;

    task automatic reset_bench();
        pend = 1'b0; lat_cnt = 0; redir_hold = 0; d_redir = 1'b0;
        pv_ar_wait = 1'b0; pv_inst_hold = 1'b0;
        exp_pc = RESET_PC; since_inst = 0;
        bus.ar_ready_i = 1'b0; bus.r_valid_i = 1'b0; bus.r_resp_i = 2'b00; bus.r_data_i = '0;
        bus.inst_ready_i = 1'b0; bus.redirect_valid_i = 1'b0; bus.redirect_pc_i = '0;
    endtask

    // one clock: called at a negedge, checks held outputs, drives inputs, updates model
    task automatic cycle();
        bit ar_hs, r_hs, inst_hs;
        if (pv_ar_wait) begin
            chk("ar_hold_valid", 64'(bus.ar_valid_o), 64'd1);
            chk("ar_hold_addr", bus.ar_addr_o, pv_ar_addr);
        end
        if (pv_inst_hold) begin
            chk("inst_hold_valid", 64'(bus.inst_valid_o), 64'd1);
            chk("inst_hold_inst", 64'(bus.inst_o), 64'(pv_inst));
            chk("inst_hold_pc", bus.pc_o, pv_pc);
            chk("inst_hold_err", 64'(bus.inst_err_o), 64'(pv_err));
        end
        if (pend) chk("one_outstanding", 64'(bus.ar_valid_o), 64'd0);

        if (rnd) begin
            bus.ar_ready_i   = ($urandom_range(0, 9) < 7);
            bus.inst_ready_i = ($urandom_range(0, 9) < 6);
            if (redir_hold > 0) begin
                redir_hold--;
            end else if ($urandom_range(0, 99) < 4) begin
                bus.redirect_valid_i = 1'b1;
                bus.redirect_pc_i    = {$urandom, $urandom};
                redir_hold           = $urandom_range(0, 2);
            end else begin
                bus.redirect_valid_i = 1'b0;
            end
        end else begin
            bus.ar_ready_i       = 1'b1;
            bus.inst_ready_i     = d_inst_ready;
            bus.redirect_valid_i = d_redir;
            bus.redirect_pc_i    = d_redir_pc;
            d_redir              = 1'b0;
        end
        bus.r_valid_i = pend && (lat_cnt == 0);
        bus.r_data_i  = bus.r_valid_i ? mem(pend_addr) : {$urandom, $urandom};
        bus.r_resp_i  = bus.r_valid_i ? resp_of(pend_addr) : 2'($urandom);

        ar_hs   = bus.ar_valid_o && bus.ar_ready_i;
        r_hs    = bus.r_valid_i && bus.r_ready_o;
        inst_hs = bus.inst_valid_o && bus.inst_ready_i;

        if (inst_hs) begin
            chk("deliver_pc", bus.pc_o, exp_pc);
            chk("deliver_inst", 64'(bus.inst_o), 64'(word(exp_pc)));
            chk("deliver_err", 64'(bus.inst_err_o), 64'(resp_of(exp_pc & ~64'd7) != 2'b00));
            ip_log.push_back(bus.pc_o);
            iw_log.push_back(bus.inst_o);
            ie_log.push_back(bus.inst_err_o);
            inst_cyc.push_back(cyc);
            exp_pc     = exp_pc + 64'd4;
            since_inst = 0;
        end else begin
            since_inst++;
        end
        if (bus.redirect_valid_i) exp_pc = bus.redirect_pc_i & ~64'd3;

        if (r_hs) pend = 1'b0;
        else if (pend && lat_cnt > 0) lat_cnt--;
        if (ar_hs) begin
            ar_log.push_back(bus.ar_addr_o);
            ar_cyc.push_back(cyc);
            pend      = 1'b1;
            pend_addr = bus.ar_addr_o;
            lat_cnt   = rnd ? int'($urandom_range(0, 3)) : d_lat;
        end

        pv_ar_wait   = bus.ar_valid_o && !bus.ar_ready_i;
        pv_ar_addr   = bus.ar_addr_o;
        pv_inst_hold = bus.inst_valid_o && !inst_hs && !bus.redirect_valid_i;
        pv_inst      = bus.inst_o;
        pv_pc        = bus.pc_o;
        pv_err       = bus.inst_err_o;

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int k;
        int n;
        rst = 1'b1;
        reset_bench();
        repeat (3) @(negedge clk);
        chk("rst_ar_valid", 64'(bus.ar_valid_o), 64'd0);
        chk("rst_r_ready", 64'(bus.r_ready_o), 64'd0);
        chk("rst_inst_valid", 64'(bus.inst_valid_o), 64'd0);
        chk("rst_inst", 64'(bus.inst_o), 64'd0);
        chk("rst_pc_o", bus.pc_o, 64'd0);
        chk("rst_err", 64'(bus.inst_err_o), 64'd0);
        rst = 1'b0;
        chk("idle_ar_valid", 64'(bus.ar_valid_o), 64'd0);
        d_inst_ready = 1'b1;
        cycle();
        chk("first_ar_valid", 64'(bus.ar_valid_o), 64'd1);
        chk("first_ar_addr", bus.ar_addr_o, 64'h8000_0000);

        // two back-to-back fetches from the reset vector
        k = 0;
        while (ip_log.size() < 2 && k < 30) begin cycle(); k++; end
        if (ip_log.size() < 2) timeout("A_fetch");
        chk("A_ar0", ar_log[0], 64'h8000_0000);
        chk("A_ar1", ar_log[1], 64'h8000_0000);
        chk("A_inst0", 64'(iw_log[0]), 64'h0010_0093);
        chk("A_inst1", 64'(iw_log[1]), 64'h0000_0013);
        chk("A_pc0", ip_log[0], 64'h8000_0000);
        chk("A_pc1", ip_log[1], 64'h8000_0004);
        chk("A_latency", 64'(inst_cyc[0] - ar_cyc[0]), 64'd2);
        chk("A_next_ar", 64'(ar_cyc[1] - inst_cyc[0]), 64'd1);

        // decode backpressure
        d_inst_ready = 1'b0;
        k = 0;
        while (!bus.inst_valid_o && k < 20) begin cycle(); k++; end
        if (!bus.inst_valid_o) timeout("B_valid");
        chk("B_pc", bus.pc_o, 64'h8000_0008);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("B_no_ar", 64'(bus.ar_valid_o), 64'd0);
        end
        d_inst_ready = 1'b1;
        n = ar_log.size();
        k = 0;
        while (ar_log.size() == n && k < 10) begin cycle(); k++; end
        if (ar_log.size() == n) timeout("B_ar");
        chk("B_next_ar", ar_log[n], 64'h8000_0008);

        // redirect while waiting on the icache
        d_lat = 3;
        k = 0;
        while (!bus.r_ready_o && k < 20) begin cycle(); k++; end
        if (!bus.r_ready_o) timeout("C_wait");
        d_redir = 1'b1; d_redir_pc = 64'h8000_1008;
        cycle();
        d_lat = 0;
        n = ip_log.size();
        k = 0;
        while (ip_log.size() == n && k < 30) begin cycle(); k++; end
        if (ip_log.size() == n) timeout("C_fetch");
        chk("C_pc", ip_log[n], 64'h8000_1008);
        chk("C_inst", 64'(iw_log[n]), 64'(mem(64'h8000_1008) & 64'hFFFF_FFFF));
        chk("C_ar", ar_log[ar_log.size() - 1], 64'h8000_1008);

        // redirect coinciding with the decode handshake
        d_inst_ready = 1'b0;
        k = 0;
        while (!bus.inst_valid_o && k < 20) begin cycle(); k++; end
        d_redir = 1'b1; d_redir_pc = 64'h8000_0010;
        cycle();
        k = 0;
        while (!bus.inst_valid_o && k < 20) begin cycle(); k++; end
        if (!bus.inst_valid_o) timeout("D_valid");
        chk("D_pc_before", bus.pc_o, 64'h8000_0010);
        d_inst_ready = 1'b1;
        d_redir = 1'b1; d_redir_pc = 64'h8000_0100;
        cycle();
        n = ip_log.size();
        k = 0;
        while (ip_log.size() == n && k < 20) begin cycle(); k++; end
        if (ip_log.size() == n) timeout("D_fetch");
        chk("D_pc_after", ip_log[n], 64'h8000_0100);

        // error response, then a clean fetch
        d_redir = 1'b1; d_redir_pc = 64'h8000_0204;
        cycle();
        n = ip_log.size();
        k = 0;
        while (ip_log.size() < n + 2 && k < 30) begin cycle(); k++; end
        if (ip_log.size() < n + 2) timeout("E_fetch");
        chk("E_pc_err", ip_log[n], 64'h8000_0204);
        chk("E_err", 64'(ie_log[n]), 64'd1);
        chk("E_pc_ok", ip_log[n + 1], 64'h8000_0208);
        chk("E_no_err", 64'(ie_log[n + 1]), 64'd0);

        // asynchronous reset in the middle of a fetch
        d_lat = 5;
        k = 0;
        while (!bus.r_ready_o && k < 20) begin cycle(); k++; end
        if (!bus.r_ready_o) timeout("F_wait");
        rst = 1'b1;
        #1;
        chk("F_ar_valid", 64'(bus.ar_valid_o), 64'd0);
        chk("F_r_ready", 64'(bus.r_ready_o), 64'd0);
        chk("F_inst_valid", 64'(bus.inst_valid_o), 64'd0);
        reset_bench();
        d_lat = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("F_ar_valid_again", 64'(bus.ar_valid_o), 64'd1);
        chk("F_ar_addr", bus.ar_addr_o, 64'h8000_0000);
        n = ip_log.size();
        k = 0;
        while (ip_log.size() == n && k < 20) begin cycle(); k++; end
        if (ip_log.size() == n) timeout("F_fetch");
        chk("F_pc", ip_log[n], RESET_PC);

        // randomized traffic against the instruction-stream model
        rnd = 1'b1;
        n = ip_log.size();
        for (int i = 0; i < 4000; i++) begin
            cycle();
            if (since_inst > 300) begin
                timeout("R_progress");
                break;
            end
        end
        chk("R_delivered", 64'(ip_log.size() - n > 100), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
